// File: rtl/vslc_servo_pkg.sv
// rtl/vslc_servo_pkg.sv - shared VSLC servo types and counter width
package vslc_servo_pkg;

    localparam int TICK_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/vslc_sync_tick.sv
// rtl/vslc_sync_tick.sv - pulse_in synchroniser, servo_clk tick detect, edge detect (VSLC_SERVO_RX_GLITCH_FILTER_EN adds majority filter)
module vslc_sync_tick
    import vslc_servo_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic servo_clk,
    input  logic pulse_in,
    output logic tick,
    output logic samp,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   servo_clk_prev;
    logic                   samp_prev;
    logic                   s;

    // Free-running regardless of reset/enable so no false edge follows release.
    always_ff @(posedge clk) begin
        sync_q         <= {sync_q[SYNC_STAGES-2:0], pulse_in};
        servo_clk_prev <= servo_clk;
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign tick = servo_clk & ~servo_clk_prev;

`ifdef VSLC_SERVO_RX_GLITCH_FILTER_EN
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (tick) begin
            hist <= {hist[0], s};
        end
    end

    assign samp = majority3(s, hist[0], hist[1]);
`else
    assign samp = s;
`endif

    always_ff @(posedge clk) begin
        if (tick) begin
            samp_prev <= samp;
        end
    end

    assign rise = samp & ~samp_prev;
    assign fall = ~samp & samp_prev;

endmodule

// File: rtl/vslc_servo_rx.sv
// rtl/vslc_servo_rx.sv - servo pulse decoder: width/period/value with timeout (VSLC_SERVO_RX_GLITCH_FILTER_EN in vslc_sync_tick)
module vslc_servo_rx
    import vslc_servo_pkg::*;
#(
    parameter int CNT_W       = TICK_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             servo_clk,
    input  logic             servo_enabled,
    input  logic             pulse_in,
    input  logic [7:0]       threshold_val,
    input  logic [CNT_W-1:0] timeout_val,
    output logic [CNT_W-1:0] width_out,
    output logic [CNT_W-1:0] period_out,
    output logic             value_out,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rx_state_t        state;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_inc;
    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] thr_ext;
    logic             timeout_hit;
    logic             tick;
    logic             samp;
    logic             rise;
    logic             fall;

    vslc_sync_tick #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_tick (
        .clk      (clk),
        .servo_clk(servo_clk),
        .pulse_in (pulse_in),
        .tick     (tick),
        .samp     (samp),
        .rise     (rise),
        .fall     (fall)
    );

    // Counters saturate so a stuck input cannot wrap into a plausible width.
    assign hi_inc      = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_ONE;
    assign per_inc     = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
    assign thr_ext     = {{(CNT_W-8){1'b0}}, threshold_val};
    assign timeout_hit = (timeout_val != '0) && (per_cnt == timeout_val);

    always_ff @(posedge clk) begin
        if (!rst_n || !servo_enabled) begin
            state      <= IDLE;
            hi_cnt     <= '0;
            per_cnt    <= '0;
            width_out  <= '0;
            period_out <= '0;
            value_out  <= 1'b0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!samp) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (rise) begin
                            hi_cnt  <= CNT_ONE;
                            per_cnt <= CNT_ONE;
                            state   <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (timeout_hit) begin
                            timeout   <= 1'b1;
                            value_out <= 1'b0;
                            state     <= IDLE;
                        end else if (fall) begin
                            per_cnt <= per_inc;
                            state   <= LOW;
                        end else begin
                            hi_cnt  <= hi_inc;
                            per_cnt <= per_inc;
                        end
                    end
                    LOW: begin
                        // A rise on the timeout tick still completes the period.
                        if (rise) begin
                            width_out  <= hi_cnt;
                            period_out <= per_cnt;
                            value_out  <= (hi_cnt > thr_ext);
                            timeout    <= 1'b0;
                            valid      <= 1'b1;
                            hi_cnt     <= CNT_ONE;
                            per_cnt    <= CNT_ONE;
                            state      <= HIGH;
                        end else if (timeout_hit) begin
                            timeout   <= 1'b1;
                            value_out <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            per_cnt <= per_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vslc_servo_rx.sv
// tb/tb_vslc_servo_rx.sv - directed bench for vslc_servo_rx
module tb_vslc_servo_rx;

    localparam int CNT_W = 16;

`ifdef VSLC_SERVO_RX_GLITCH_FILTER_EN
    localparam int GL_W = 10;
    localparam int GL_P = 40;
`else
    localparam int GL_W = 1;
    localparam int GL_P = 20;
`endif

    logic             clk           = 1'b0;
    logic             rst_n         = 1'b0;
    logic             servo_clk     = 1'b0;
    logic             servo_enabled = 1'b0;
    logic             pulse_in      = 1'b0;
    logic [7:0]       threshold_val = 8'd8;
    logic [CNT_W-1:0] timeout_val   = '0;
    logic [CNT_W-1:0] width_out;
    logic [CNT_W-1:0] period_out;
    logic             value_out;
    logic             valid;
    logic             timeout;

    int n_cmp      = 0;
    int n_err      = 0;
    int div        = 2;
    int valid_cnt  = 0;
    int valid_wide = 0;
    int v0;
    logic             valid_q = 1'b0;
    logic [CNT_W-1:0] cap_w   = '0;
    logic [CNT_W-1:0] cap_p   = '0;
    logic             cap_v   = 1'b0;

    vslc_servo_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .servo_clk    (servo_clk),
        .servo_enabled(servo_enabled),
        .pulse_in     (pulse_in),
        .threshold_val(threshold_val),
        .timeout_val  (timeout_val),
        .width_out    (width_out),
        .period_out   (period_out),
        .value_out    (value_out),
        .valid        (valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            cap_w     = width_out;
            cap_p     = period_out;
            cap_v     = value_out;
            if (valid_q) valid_wide = valid_wide + 1;
        end
        valid_q = valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One servo_clk period of div clk carrying pulse level p.
    task automatic do_tick(input logic p);
        @(negedge clk);
        pulse_in  = p;
        servo_clk = 1'b0;
        repeat (div / 2 - 1) @(negedge clk);
        @(negedge clk);
        servo_clk = 1'b1;
        repeat (div - div / 2 - 1) @(negedge clk);
    endtask

    task automatic train(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) do_tick(1'b1);
            for (int i = 0; i < lo; i++) do_tick(1'b0);
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        settle();
        check_eq("rst_width", width_out, 0);
        check_eq("rst_period", period_out, 0);
        check_eq("rst_value", value_out, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        servo_enabled = 1'b1;

        // 10 high / 90 low, threshold 8
        train(10, 90, 2);
        settle();
        check_eq("t1_vcnt", valid_cnt, 1);
        check_eq("t1_width", cap_w, 10);
        check_eq("t1_period", cap_p, 100);
        check_eq("t1_value", cap_v, 1);

        threshold_val = 8'd10;
        train(10, 90, 1);
        settle();
        check_eq("thr10_vcnt", valid_cnt, 2);
        check_eq("thr10_value", cap_v, 0);
        check_eq("thr10_width", width_out, 10);

        threshold_val = 8'd9;
        train(10, 90, 1);
        settle();
        check_eq("thr9_value", value_out, 1);

        // Timeout at per_cnt == 50
        timeout_val = 16'd50;
        v0 = valid_cnt;
        for (int i = 0; i < 10; i++) do_tick(1'b1);
        for (int i = 0; i < 80; i++) do_tick(1'b0);
        settle();
        check_eq("to_vcnt", valid_cnt, v0 + 1);
        check_eq("to_flag", timeout, 1);
        check_eq("to_value", value_out, 0);
        check_eq("to_width_held", width_out, 10);
        check_eq("to_period_held", period_out, 100);
        train(10, 30, 1);
        settle();
        check_eq("to_armed_sticky", timeout, 1);
        check_eq("to_armed_vcnt", valid_cnt, v0 + 1);
        train(10, 30, 1);
        settle();
        timeout_val = '0;
        check_eq("to_clear", timeout, 0);
        check_eq("to_clear_vcnt", valid_cnt, v0 + 2);
        check_eq("to_clear_period", cap_p, 40);
        check_eq("to_clear_value", cap_v, 1);

        // Enable while pulse_in already high
        @(negedge clk);
        servo_enabled = 1'b0;
        settle();
        check_eq("dis_width", width_out, 0);
        check_eq("dis_period", period_out, 0);
        for (int i = 0; i < 3; i++) do_tick(1'b1);
        servo_enabled = 1'b1;
        v0 = valid_cnt;
        for (int i = 0; i < 7; i++) do_tick(1'b1);
        for (int i = 0; i < 30; i++) do_tick(1'b0);
        train(10, 30, 1);
        settle();
        check_eq("en_hi_novalid", valid_cnt, v0);
        check_eq("en_hi_width0", width_out, 0);
        train(10, 30, 1);
        settle();
        check_eq("en_hi_vcnt", valid_cnt, v0 + 1);
        check_eq("en_hi_width", cap_w, 10);
        check_eq("en_hi_period", cap_p, 40);

        // servo_clk period 4 clk, 5 high / 15 low
        div = 4;
        v0 = valid_cnt;
        train(5, 15, 2);
        settle();
        check_eq("div4_vcnt", valid_cnt, v0 + 2);
        check_eq("div4_width", cap_w, 5);
        check_eq("div4_period", cap_p, 20);

        // 1-clk reset during HIGH
        for (int i = 0; i < 3; i++) do_tick(1'b1);
        settle();
        check_eq("pre_rst_width", width_out, 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rst_width", width_out, 0);
        check_eq("mid_rst_period", period_out, 0);
        check_eq("mid_rst_value", value_out, 0);
        check_eq("mid_rst_timeout", timeout, 0);
        v0 = valid_cnt;
        for (int i = 0; i < 2; i++) do_tick(1'b1);
        for (int i = 0; i < 15; i++) do_tick(1'b0);
        train(5, 15, 1);
        settle();
        check_eq("post_rst_novalid", valid_cnt, v0);
        train(5, 15, 1);
        settle();
        check_eq("post_rst_vcnt", valid_cnt, v0 + 1);
        check_eq("post_rst_period", cap_p, 20);

        // Single-tick glitch in LOW
        div = 2;
        for (int i = 0; i < 10; i++) do_tick(1'b1);
        for (int i = 0; i < 10; i++) do_tick(1'b0);
        do_tick(1'b1);
        for (int i = 0; i < 19; i++) do_tick(1'b0);
        for (int i = 0; i < 3; i++) do_tick(1'b1);
        settle();
        check_eq("glitch_width", cap_w, GL_W);
        check_eq("glitch_period", cap_p, GL_P);

        check_eq("valid_one_clk", valid_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
